mem_port_arbiter: RTL

Shares one single-port synchronous memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the multi-cycle CPU. It arbitrates between the two requesters round-robin, then sequences each access through issue, latency wait and response. It returns read data with a one-cycle acknowledge pulse. It sits between the IF/MEM stage logic and the unified memory macro, so the design needs only one memory.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/arb_rr2.sv | 12 +
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } arb_state_e;

  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_DM = 1'b1;

  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W = $clog2(MEM_LAT_MAX + 1);

  typedef struct packed {
    logic        src;
    logic        we;
    logic        err;
    logic [31:0] wdata;
  } txn_t;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a tie goes to the side not served last.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       valid
);

  assign gnt   = (&req) ? (last ? 2'b01 : 2'b10) : req;
  assign valid = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the IF and MEM stages.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ack,
  output logic [31:0]       dm_rdata,
  output logic              dm_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  txn_t              txn_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;
  logic              if_ack_q;
  logic              dm_ack_q;
  logic              dm_err_q;
  logic              busy_q;
  logic [31:0]       if_rdata_q;
  logic [31:0]       dm_rdata_q;

  logic [1:0] gnt;
  logic       gnt_vld;
  logic       gsrc;
  logic       grant;
  logic       issue;
  logic       unused_bits;

  arb_rr2 u_rr (
    .req   ({dm_req, if_req}),
    .last  (last_q),
    .gnt   (gnt),
    .valid (gnt_vld)
  );

  // The ack cycle is still part of the access: requests are not resampled
  // until the requester has seen its ack and had a cycle to drop req.
  assign grant = gnt_vld & ~(if_ack_q | dm_ack_q);
  assign gsrc  = gnt[1];

  assign unused_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         dm_addr[31:ADDR_W+2], gnt[0]};

  assign issue     = (state_q == S_ISSUE) & ~txn_q.err;
  assign mem_en    = issue;
  assign mem_we    = issue & txn_q.we;
  assign mem_addr  = issue ? addr_q : '0;
  assign mem_wdata = issue ? txn_q.wdata : '0;

  assign if_ack   = if_ack_q;
  assign if_rdata = if_rdata_q;
  assign dm_ack   = dm_ack_q;
  assign dm_rdata = dm_rdata_q;
  assign dm_err   = dm_err_q;
  assign busy     = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      txn_q      <= '0;
      addr_q     <= '0;
      last_q     <= SRC_IF;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      dm_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      dm_err_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      unique case (state_q)
        S_IDLE: begin
          busy_q <= grant;
          if (grant) begin
            txn_q.src   <= gsrc;
            txn_q.we    <= gsrc & dm_we;
            txn_q.err   <= gsrc & misaligned(dm_addr[1:0]);
            txn_q.wdata <= (gsrc & dm_we) ? dm_wdata : '0;
            addr_q      <= gsrc ? dm_addr[ADDR_W+1:2]
                                : if_addr[ADDR_W+1:2];
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= CNT_W'(MEM_LAT - 1);
          state_q <= (MEM_LAT > 1) ? S_WAIT : S_DONE;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (txn_q.src == SRC_DM) begin
            dm_ack_q   <= 1'b1;
            dm_err_q   <= txn_q.err;
            dm_rdata_q <= (txn_q.we | txn_q.err) ? '0 : mem_rdata;
          end else begin
            if_ack_q   <= 1'b1;
            if_rdata_q <= mem_rdata;
          end
          last_q  <= txn_q.src;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
